// File: rtl/mycpu_pkg.sv
// Shared mycpu types: boot sequencer states, status flags and default constants.
package mycpu_pkg;

  localparam int unsigned BOOT_PROG_WORDS      = 256;
  localparam int unsigned BOOT_WATCHDOG_CYCLES = 4000;
  localparam int unsigned BOOT_RELEASE_CYCLES  = 2;

  typedef enum logic [2:0] {
    B_IDLE,
    B_LOAD,
    B_RELEASE,
    B_RUN,
    B_HALTED,
    B_TIMEOUT
  } boot_state_t;

  typedef struct packed {
    logic ld_ready;
    logic cpu_rst_n;
    logic busy;
    logic done;
    logic timeout;
  } boot_flags_t;

  // Status flags that hold while the sequencer sits in state s.
  function automatic boot_flags_t boot_flags(input boot_state_t s);
    boot_flags_t f;
    f.ld_ready  = (s == B_LOAD);
    f.cpu_rst_n = (s == B_RUN) || (s == B_HALTED);
    f.busy      = (s == B_LOAD) || (s == B_RELEASE) || (s == B_RUN);
    f.done      = (s == B_HALTED);
    f.timeout   = (s == B_TIMEOUT);
    return f;
  endfunction

endpackage

// File: rtl/mycpu_bus_mux.sv
// Memory bus selection: loader during load, CPU during run, idle-zero otherwise.
module mycpu_bus_mux #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          sel_load,
  input  logic          sel_cpu,
  input  logic          wr_block,
  input  logic [AW-1:0] ld_a,
  input  logic [DW-1:0] ld_d,
  input  logic          ld_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_d,
  input  logic          cpu_wen,
  input  logic          cpu_iom,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_we
);

  // Source select; I/O cycles never reach memory and wr_block kills any write.
  always_comb begin
    mem_a  = '0;
    mem_d  = '0;
    mem_we = 1'b0;
    if (sel_load) begin
      mem_a  = ld_a;
      mem_d  = ld_d;
      mem_we = ld_we;
    end else if (sel_cpu) begin
      mem_a  = cpu_a;
      mem_d  = cpu_d;
      mem_we = cpu_wen && !cpu_iom;
    end
    if (wr_block) mem_we = 1'b0;
  end

endmodule

// File: rtl/mycpu_boot_ctrl.sv
// Boot/run sequencer: holds the CPU in reset, loads the image, releases and supervises the run.
module mycpu_boot_ctrl
  import mycpu_pkg::*;
#(
  parameter int unsigned AW              = 16,
  parameter int unsigned DW              = 16,
  parameter int unsigned PROG_WORDS      = BOOT_PROG_WORDS,
  parameter int unsigned LOAD_BASE       = 0,
  parameter int unsigned RELEASE_CYCLES  = BOOT_RELEASE_CYCLES,
  parameter int unsigned WATCHDOG_CYCLES = BOOT_WATCHDOG_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_d,
  input  logic          cpu_wen,
  input  logic          cpu_iom,
  input  logic          cpu_halted,
  output logic          cpu_rst_n,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_we,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [AW-1:0] words_loaded,
  output logic [31:0]   run_cycles
);

  localparam int unsigned RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  boot_state_t   state;
  boot_state_t   state_nx;
  boot_flags_t   flg;
  logic [AW-1:0] addr;
  logic [RW-1:0] rel_cnt;
  logic          xfer;
  logic          last_xfer;
  logic          rel_done;
  logic          wd_hit;

  // Handshake and terminal-count events for the current cycle.
  always_comb begin
    xfer      = (state == B_LOAD) && ld_valid && !abort;
    last_xfer = xfer && (ld_last || (words_loaded == AW'(PROG_WORDS - 1)));
    rel_done  = (rel_cnt == RW'(RELEASE_CYCLES - 1));
    wd_hit    = (run_cycles == 32'(WATCHDOG_CYCLES - 1));
  end

  // Next state; abort overrides everything, halt beats the watchdog.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = B_IDLE;
    end else begin
      case (state)
        B_IDLE, B_HALTED, B_TIMEOUT: if (start) state_nx = B_LOAD;
        B_LOAD:    if (last_xfer) state_nx = B_RELEASE;
        B_RELEASE: if (rel_done) state_nx = B_RUN;
        B_RUN: begin
          if (cpu_halted)  state_nx = B_HALTED;
          else if (wd_hit) state_nx = B_TIMEOUT;
        end
        default: state_nx = B_IDLE;
      endcase
    end
  end

  // State, registered status flags and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= B_IDLE;
      flg          <= '0;
      addr         <= '0;
      rel_cnt      <= '0;
      words_loaded <= '0;
      run_cycles   <= '0;
    end else begin
      state <= state_nx;
      flg   <= boot_flags(state_nx);

      // Load address and word count; the address stops on the final word.
      if (state_nx == B_LOAD && state != B_LOAD) begin
        addr         <= AW'(LOAD_BASE);
        words_loaded <= '0;
      end else if (xfer) begin
        words_loaded <= words_loaded + 1'b1;
        if (!last_xfer) addr <= addr + 1'b1;
      end

      rel_cnt <= (state == B_RELEASE) ? rel_cnt + 1'b1 : '0;

      // Run length; frozen on the exit cycle so it reads the cycle of the exit event.
      if (state == B_LOAD && state_nx == B_RELEASE) begin
        run_cycles <= '0;
      end else if (state == B_RUN && state_nx == B_RUN) begin
        run_cycles <= run_cycles + 32'd1;
      end
    end
  end

  assign ld_ready  = flg.ld_ready;
  assign cpu_rst_n = flg.cpu_rst_n;
  assign busy      = flg.busy;
  assign done      = flg.done;
  assign timeout   = flg.timeout;

  mycpu_bus_mux #(
    .AW(AW),
    .DW(DW)
  ) u_bus_mux (
    .sel_load (state == B_LOAD),
    .sel_cpu  (state == B_RUN),
    .wr_block (rst),
    .ld_a     (addr),
    .ld_d     (ld_data),
    .ld_we    (xfer),
    .cpu_a    (cpu_a),
    .cpu_d    (cpu_d),
    .cpu_wen  (cpu_wen),
    .cpu_iom  (cpu_iom),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .mem_we   (mem_we)
  );

endmodule

// File: tb/tb_mycpu_boot_ctrl.sv
// Bench for mycpu_boot_ctrl: behavioural model checked every cycle plus directed literal checks.
module tb_mycpu_boot_ctrl;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 16;
  localparam int unsigned PW   = 256;
  localparam int unsigned BASE = 0;
  localparam int unsigned RC   = 2;
  localparam int unsigned WD   = 100;

  localparam int P_IDLE = 0, P_LOAD = 1, P_REL = 2, P_RUN = 3, P_HALT = 4, P_TMO = 5;

  logic          clk = 1'b0;
  logic          rst, start, abort, ld_valid, ld_last, cpu_wen, cpu_iom, cpu_halted;
  logic [DW-1:0] ld_data, cpu_d;
  logic [AW-1:0] cpu_a;
  logic          ld_ready, cpu_rst_n, mem_we, busy, done, timeout;
  logic [AW-1:0] mem_a, words_loaded;
  logic [DW-1:0] mem_d;
  logic [31:0]   run_cycles;

  int n_tests = 0;
  int n_fail  = 0;
  int ph      = P_IDLE;
  int m_words = 0;
  int m_run   = 0;
  int m_rel   = 0;
  int n_wr    = 0;
  logic [AW-1:0] last_wa = '0;
  logic [DW-1:0] last_wd = '0;

  mycpu_boot_ctrl #(
    .AW(AW), .DW(DW), .PROG_WORDS(PW), .LOAD_BASE(BASE),
    .RELEASE_CYCLES(RC), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_wen(cpu_wen), .cpu_iom(cpu_iom),
    .cpu_halted(cpu_halted), .cpu_rst_n(cpu_rst_n),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we),
    .busy(busy), .done(done), .timeout(timeout),
    .words_loaded(words_loaded), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: phase plus counts, advanced on every clock edge.
  always @(posedge clk) begin
    if (rst) begin
      ph <= P_IDLE; m_words <= 0; m_run <= 0; m_rel <= 0;
    end else if (abort) begin
      ph <= P_IDLE;
    end else begin
      case (ph)
        P_IDLE, P_HALT, P_TMO: if (start) begin ph <= P_LOAD; m_words <= 0; end
        P_LOAD: if (ld_valid) begin
          m_words <= m_words + 1;
          if (ld_last || (m_words + 1 == int'(PW))) begin
            ph <= P_REL; m_rel <= 0; m_run <= 0;
          end
        end
        P_REL: if (m_rel + 1 == int'(RC)) ph <= P_RUN; else m_rel <= m_rel + 1;
        P_RUN: begin
          if (cpu_halted)               ph <= P_HALT;
          else if (m_run == int'(WD) - 1) ph <= P_TMO;
          else                          m_run <= m_run + 1;
        end
        default: ph <= P_IDLE;
      endcase
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    ea = '0; ed = '0; ew = 1'b0;
    if (ph == P_LOAD) begin
      ea = AW'(BASE + m_words); ed = ld_data; ew = ld_valid && !abort;
    end else if (ph == P_RUN) begin
      ea = cpu_a; ed = cpu_d; ew = cpu_wen && !cpu_iom;
    end
    if (rst) ew = 1'b0;
    chk("m_ld_ready",  32'(ld_ready),  32'(ph == P_LOAD));
    chk("m_cpu_rst_n", 32'(cpu_rst_n), 32'(ph == P_RUN || ph == P_HALT));
    chk("m_busy",      32'(busy),      32'(ph == P_LOAD || ph == P_REL || ph == P_RUN));
    chk("m_done",      32'(done),      32'(ph == P_HALT));
    chk("m_timeout",   32'(timeout),   32'(ph == P_TMO));
    chk("m_words",     32'(words_loaded), 32'(m_words));
    chk("m_run",       run_cycles,     32'(m_run));
    chk("m_mem_we",    32'(mem_we),    32'(ew));
    chk("m_mem_a",     32'(mem_a),     32'(ea));
    chk("m_mem_d",     32'(mem_d),     32'(ed));
    if (mem_we === 1'b1) begin
      n_wr++; last_wa = mem_a; last_wd = mem_d;
    end
  end

  initial begin
    #100000;
    $display("FAIL time_limit: got no finish expected finish by 100000");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int wr0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_data = '0; cpu_a = '0; cpu_d = '0; cpu_wen = 1'b0; cpu_iom = 1'b0; cpu_halted = 1'b0;
    repeat (2) cyc();
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_ld_ready",  32'(ld_ready),  32'd0);
    chk("rst_words",     32'(words_loaded), 32'd0);
    chk("rst_run",       run_cycles,     32'd0);
    rst = 1'b0;
    cyc();

    // Four-word image with a one-cycle gap.
    start = 1'b1; cyc(); start = 1'b0;
    chk("load_ready", 32'(ld_ready), 32'd1);
    wr0 = n_wr;
    for (int i = 0; i < 5; i++) begin
      ld_valid = (i != 2);
      ld_data  = (i < 2) ? DW'(16'h1111 * (i + 1)) : DW'(16'h1111 * i);
      ld_last  = (i == 4);
      cyc();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("img4_words",   32'(words_loaded), 32'd4);
    chk("img4_writes",  32'(n_wr - wr0),   32'd4);
    chk("img4_last_a",  32'(last_wa),      32'd3);
    chk("img4_last_d",  32'(last_wd),      32'h4444);
    n = 0;
    while (cpu_rst_n !== 1'b1 && n < 10) begin cyc(); n++; end
    chk("release_len", 32'(n), 32'd2);

    // Run with CPU traffic, halt at run cycle 50.
    for (int i = 0; i < 50; i++) begin
      cpu_a = AW'(16'h100 + i); cpu_d = DW'(i * 3);
      cpu_wen = (i % 2 == 1); cpu_iom = (i % 4 == 1);
      if (i == 10) begin cpu_wen = 1'b1; cpu_iom = 1'b1; #1 chk("iom_gate", 32'(mem_we), 32'd0); end
      if (i == 11) begin cpu_wen = 1'b1; cpu_iom = 1'b0; #1 chk("cpu_wr", 32'(mem_we), 32'd1); end
      cyc();
    end
    cpu_halted = 1'b1; cpu_wen = 1'b1; cpu_iom = 1'b0;
    cyc();
    cpu_halted = 1'b0;
    chk("halt_done",   32'(done),      32'd1);
    chk("halt_run",    run_cycles,     32'd50);
    chk("halt_rst_n",  32'(cpu_rst_n), 32'd1);
    chk("halt_mem_we", 32'(mem_we),    32'd0);
    cpu_wen = 1'b0;

    // Reload from HALTED, abort after two words.
    start = 1'b1; cyc(); start = 1'b0;
    chk("reload_rst_n", 32'(cpu_rst_n), 32'd0);
    ld_valid = 1'b1; ld_data = 16'hA001; cyc();
    ld_data = 16'hA002; cyc();
    ld_valid = 1'b0; abort = 1'b1; cyc(); abort = 1'b0;
    chk("abort_words", 32'(words_loaded), 32'd2);
    chk("abort_busy",  32'(busy),         32'd0);

    // Overlong stream stops at PROG_WORDS.
    start = 1'b1; cyc(); start = 1'b0;
    wr0 = n_wr; n = 0; ld_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ld_data = DW'(i);
      cyc(); n++;
      if (ld_ready !== 1'b1) break;
    end
    chk("cap_offered", 32'(n),          32'd256);
    chk("cap_writes",  32'(n_wr - wr0), 32'd256);
    chk("cap_last_a",  32'(last_wa),    32'd255);
    chk("cap_words",   32'(words_loaded), 32'd256);
    chk("cap_release", 32'(busy && !cpu_rst_n && !ld_ready), 32'd1);
    cyc();
    ld_valid = 1'b0;
    cyc();
    chk("run_entry", 32'(cpu_rst_n), 32'd1);

    // Watchdog expiry.
    n = 0;
    while (timeout !== 1'b1 && n < 200) begin cyc(); n++; end
    chk("wd_cycles",  32'(n),         32'd100);
    chk("wd_run",     run_cycles,     32'd99);
    chk("wd_rst_n",   32'(cpu_rst_n), 32'd0);

    // Reload from TIMEOUT; start ignored in RUN; halt and watchdog together.
    start = 1'b1; cyc(); start = 1'b0;
    chk("tmo_reload", 32'(ld_ready), 32'd1);
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = 16'h7777; cyc();
    ld_valid = 1'b0; ld_last = 1'b0;
    repeat (2) cyc();
    for (int i = 0; i < 99; i++) begin
      start = (i == 20);
      cyc();
      if (i == 20) chk("start_in_run", 32'(busy && cpu_rst_n && !ld_ready), 32'd1);
    end
    start = 1'b0;
    chk("pre_tie_run", run_cycles, 32'd99);
    cpu_halted = 1'b1; cyc(); cpu_halted = 1'b0;
    chk("tie_done",    32'(done),    32'd1);
    chk("tie_timeout", 32'(timeout), 32'd0);
    chk("tie_run",     run_cycles,   32'd99);

    // Synchronous reset in the middle of a run.
    start = 1'b1; cyc(); start = 1'b0;
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = 16'h1234; cyc();
    ld_valid = 1'b0; ld_last = 1'b0;
    repeat (2) cyc();
    cpu_wen = 1'b1; cpu_iom = 1'b0; cpu_a = 16'h0055; cpu_d = 16'hBEEF;
    repeat (3) cyc();
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1 chk("rst_blocks_we", 32'(mem_we), 32'd0);
    cyc();
    chk("mid_rst_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("mid_rst_flags", 32'({busy, done, timeout, ld_ready}), 32'd0);
    chk("mid_rst_words", 32'(words_loaded), 32'd0);
    chk("mid_rst_run",   run_cycles, 32'd0);
    chk("mid_rst_bus",   32'({mem_a, mem_d}), 32'd0);
    rst = 1'b0; cpu_wen = 1'b0;
    cyc();
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
